hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Pipeline hazard sequencer for the ARM 5-stage core.
- Detects load-use and taken-branch hazards, and honours external memory-wait stalls.
- Drives PC and IF/ID register enables, the IF/ID flush, and the NOP-insert select of the control-unit mux feeding ID/EX.
- Sits beside the decode stage. Holds a small FSM for multi-cycle stalls/flushes and saturating performance counters.

Parameters:
- REG_ADDR_W, 4, register-address width.
- LOAD_STALL_CYCLES, 1, bubble cycles per load-use hazard (>=1).
- FLUSH_CYCLES, 1, cycles IF/ID flush is held per taken branch (>=1).
- CNT_W, 16, width of performance counters.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- id_rn  input  REG_ADDR_W  ID-stage Rn address.
- id_rm  input  REG_ADDR_W  ID-stage Rm address.
- id_uses_rn  input  1  ID instruction reads Rn.
- id_uses_rm  input  1  ID instruction reads Rm.
- ex_rd  input  REG_ADDR_W  EX-stage destination.
- ex_mem_to_reg  input  1  EX instruction is a load.
- ex_reg_write  input  1  EX instruction writes a register.
- branch_taken  input  1  taken branch resolved in ID this cycle.
- ext_stall  input  1  memory not ready; freeze front end.
- pc_load_enable  output  1  PC register enable.
- if_id_load_enable  output  1  IF/ID register enable.
- if_id_flush  output  1  clear IF/ID to NOP on next edge.
- cu_nop_select  output  1  forces cu mux outputs to zero (bubble into EX).
- state_out  output  2  current FSM state (00 RUN, 01 LU_STALL, 10 FLUSH).
- stall_count  output  CNT_W  cycles with pc_load_enable=0, saturating.
- flush_count  output  CNT_W  taken-branch flush events, saturating.

Behaviour:
- load_use = ex_mem_to_reg & ex_reg_write & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)). Combinational.
- Outputs are combinational from the registered state plus inputs. State and counters update on the rising clk edge.
- While reset=1: pc_load_enable=0, if_id_load_enable=0, if_id_flush=1, cu_nop_select=1, state_out=00. On the edge with reset=1: state<=RUN, internal down-counter<=0, stall_count<=0, flush_count<=0. Reset mid-stall or mid-flush aborts it immediately.
- Priority in every state: ext_stall > state-held action > load_use > branch_taken.
- ext_stall=1 (any state):
  - Outputs: pc=0, ifid=0, flush=0, nop=1.
  - State and down-counter frozen; flush_count not incremented.
  - stall_count increments.
  - Branch or load_use seen this cycle is not registered (re-evaluated once the stall drops).
- RUN, no hazard: pc=1, ifid=1, flush=0, nop=0.
- RUN, load_use:
  - Outputs: pc=0, ifid=0, nop=1, flush=0.
  - If LOAD_STALL_CYCLES>1: next=LU_STALL, down-counter<=LOAD_STALL_CYCLES-2. Else remain RUN.
- RUN, branch_taken (no load_use):
  - Outputs: pc=1, ifid=0, flush=1, nop=0.
  - flush_count++.
  - If FLUSH_CYCLES>1: next=FLUSH, down-counter<=FLUSH_CYCLES-2.
- load_use and branch_taken together: load_use wins (branch operands stale); branch is re-presented next cycle.
- LU_STALL:
  - Outputs as load_use stall; load_use and branch_taken ignored.
  - Counter==0 -> RUN, else decrement.
- FLUSH:
  - Outputs: pc=1, ifid=0, flush=1, nop=0.
  - branch_taken and load_use ignored (ID holds a flushed NOP).
  - Counter==0 -> RUN, else decrement.
- Counters saturate at all-ones and never wrap.
- The unused state encoding 11 recovers to RUN on the next edge, with RUN outputs.

Test Plan:
- Reset held 3 cycles, then released with no hazards. During reset: pc=0, flush=1, nop=1. From the first cycle after release: pc=1, ifid=1, nop=0, counters 0.
- Load r3 in EX (ex_mem_to_reg=1, ex_reg_write=1, ex_rd=3), ID uses_rn=1 with id_rn=3, LOAD_STALL_CYCLES=1. Exactly one cycle of pc=0/ifid=0/nop=1, then RUN outputs; stall_count=1. Repeat with LOAD_STALL_CYCLES=3: three stall cycles, state_out 00->01->01->00.
- Same load with ID uses_rn=0, id_rn=3 -> no stall.
- branch_taken pulse for 1 cycle with FLUSH_CYCLES=2. flush=1 for 2 cycles, pc=1 throughout, flush_count=1. branch_taken asserted again during FLUSH is ignored (flush_count stays 1).
- load_use and branch_taken in the same cycle. Cycle 1: stall (nop=1, flush=0). Cycle 2: flush=1, flush_count=1.
- ext_stall in 2nd cycle of LU_STALL (LOAD_STALL_CYCLES=3) for 4 cycles: state frozen at 01, stall_count +4, then stall completes its remaining cycles. Separately, reset mid-FLUSH -> state 00 and counters 0 on the next cycle. Force CNT_W=4 and stall 20 cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline hazard sequencer for the 5-stage ARM core. It sits beside decode
// and resolves load-use bubbles, taken-branch flushes and external memory-wait
// freezes into PC / IF/ID enables, an IF/ID flush and the bubble-insert select
// of the control-unit mux. Multi-cycle bubbles and flushes are timed by one
// shared down-counter. Two saturating counters give stall and flush statistics.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | normal issue; load-use and taken-branch detection active
// ST_LU_STALL| extra load-use bubble cycles beyond the first
// ST_FLUSH   | extra IF/ID flush cycles beyond the first
// ST_ILLEGAL | unused encoding; behaves like RUN and recovers on next edge
//
// Priority in every state: ext_stall > state-held action > load_use > branch.

module hazard_controller #(
    parameter int REG_ADDR_W        = 4,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rn,
    input  logic [REG_ADDR_W-1:0] id_rm,
    input  logic                  id_uses_rn,
    input  logic                  id_uses_rm,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_reg_write,
    input  logic                  branch_taken,
    input  logic                  ext_stall,
    output logic                  pc_load_enable,
    output logic                  if_id_load_enable,
    output logic                  if_id_flush,
    output logic                  cu_nop_select,
    output logic [1:0]            state_out,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    // The first bubble / flush cycle is issued from RUN, so the down-counter
    // only has to cover the remaining (N-1) cycles, i.e. reload with N-2.
    localparam int DC_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES
                                                               : FLUSH_CYCLES;
    localparam int DC_W   = (DC_MAX > 2) ? $clog2(DC_MAX - 1) : 1;

    localparam logic [DC_W-1:0] LU_RELOAD =
        DC_W'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);
    localparam logic [DC_W-1:0] FLUSH_RELOAD =
        DC_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
    localparam logic [DC_W-1:0] DC_ONE = DC_W'(1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    state_t          state;
    logic [DC_W-1:0] dcnt;

    logic rn_hit;
    logic rm_hit;
    logic load_use;

    // A load in EX whose destination feeds an operand decode actually reads.
    always_comb begin
        rn_hit   = id_uses_rn && (id_rn == ex_rd);
        rm_hit   = id_uses_rm && (id_rm == ex_rd);
        load_use = ex_mem_to_reg && ex_reg_write && (rn_hit || rm_hit);
    end

    // Front-end controls from the registered state and this cycle's hazards.
    always_comb begin
        pc_load_enable    = 1'b1;
        if_id_load_enable = 1'b1;
        if_id_flush       = 1'b0;
        cu_nop_select     = 1'b0;
        if (reset) begin
            pc_load_enable    = 1'b0;
            if_id_load_enable = 1'b0;
            if_id_flush       = 1'b1;
            cu_nop_select     = 1'b1;
        end else if (ext_stall) begin
            pc_load_enable    = 1'b0;
            if_id_load_enable = 1'b0;
            cu_nop_select     = 1'b1;
        end else begin
            case (state)
                ST_LU_STALL: begin
                    pc_load_enable    = 1'b0;
                    if_id_load_enable = 1'b0;
                    cu_nop_select     = 1'b1;
                end
                ST_FLUSH: begin
                    if_id_load_enable = 1'b0;
                    if_id_flush       = 1'b1;
                end
                ST_RUN: begin
                    if (load_use) begin
                        pc_load_enable    = 1'b0;
                        if_id_load_enable = 1'b0;
                        cu_nop_select     = 1'b1;
                    end else if (branch_taken) begin
                        if_id_load_enable = 1'b0;
                        if_id_flush       = 1'b1;
                    end
                end
                default: begin
                    // Unused encoding: plain RUN outputs while it recovers.
                end
            endcase
        end
    end

    // State observed outside reads RUN while reset is held.
    always_comb begin
        state_out = reset ? 2'b00 : state;
    end

    // Sequencer state and shared down-counter; frozen while memory waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            dcnt  <= '0;
        end else if (state == ST_ILLEGAL) begin
            state <= ST_RUN;
            dcnt  <= '0;
        end else if (!ext_stall) begin
            case (state)
                ST_RUN: begin
                    if (load_use) begin
                        if (LOAD_STALL_CYCLES > 1) begin
                            state <= ST_LU_STALL;
                            dcnt  <= LU_RELOAD;
                        end
                    end else if (branch_taken) begin
                        if (FLUSH_CYCLES > 1) begin
                            state <= ST_FLUSH;
                            dcnt  <= FLUSH_RELOAD;
                        end
                    end
                end
                ST_LU_STALL, ST_FLUSH: begin
                    if (dcnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        dcnt <= dcnt - DC_ONE;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    dcnt  <= '0;
                end
            endcase
        end
    end

    // Saturating statistics: every frozen-PC cycle, and each branch that
    // starts a flush (cycles held inside FLUSH are not new events).
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_load_enable && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
            if (!ext_stall && (state == ST_RUN) && !load_use && branch_taken &&
                (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_ONE;
            end
        end
    end

endmodule
